jedro_1_core: RTL and testbench
===============================

# jedro_1_core

Minimal RV32I integer core: fetches 32-bit instructions from a synchronous-read instruction memory and executes register-immediate ALU instructions and LUI in a three-stage in-order pipeline (fetch, decode-register, execute/writeback). It sits between the instruction ROM and the data RAM wrapper. Its register file is checked hierarchically by benches. Loads, stores, branches and jumps are out of scope for this block; the data memory port is present but held idle.

## Interface
- DATA_WIDTH, 32: instruction and data word width.
- ADDR_WIDTH, 32: instruction and data address width.
- clk_i  input  1  single clock, all state on rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- instr_addr_o  output  ADDR_WIDTH  byte address of the instruction being fetched (the PC).
- instr_rdata_i  input  DATA_WIDTH  instruction word, valid one cycle after the address.
- data_addr_o  output  ADDR_WIDTH  data memory address; constant 0.
- data_wdata_o  output  DATA_WIDTH  data write data; constant 0.
- data_we_o  output  4  byte write enables; constant 0.
- data_rdata_i  input  DATA_WIDTH  data read data; ignored.
- Register file instance named regfile_inst, storage array regfile[0:31] of 32-bit words, reachable hierarchically.

## Operation
- Supported (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- Supported (opcode 0110111): LUI, rd = {imm[31:12], 12'b0}.
- Every other encoding executes as a NOP: no register write and no exception.
- I-immediate is instr[31:20], sign-extended to 32 bits.
- SLTI: signed compare of rs1 with the immediate; writes 1 or 0.
- SLTIU: unsigned compare of rs1 with the sign-extended immediate; writes 1 or 0.
  - Example: imm -1 compares as 0xFFFFFFFF.
- Shifts use shamt = instr[24:20].
  - SRAI is selected by instr[30]=1 under funct3 101; SRLI otherwise.
- x0 reads as 0. Writes to x0 are discarded.
- Regfile has two combinational read ports and one synchronous write port.
- Regfile is read in the execute stage. A result written at an edge is seen by the next instruction, so no forwarding or stalls are needed.
- PC starts at 0 and increments by 4 every cycle. There is no wrap handling beyond 32-bit modulo arithmetic.

## Timing
- Reset (asynchronous):
  - PC = 0.
  - fetch-valid flag = 0.
  - decode register = NOP (0x00000013) with valid = 0.
  - All 32 registers = 0.
  - All data outputs = 0.
- Cycle t: instr_addr_o = A.
- Edge t+1: PC <= A+4 and fetch-valid <= 1. The memory returns the word for A during cycle t+1.
- Edge t+2: decode register <= instr_rdata_i, qualified by fetch-valid.
- Edge t+3: rd is written.
- Total latency from address issue to regfile update is 3 edges. Throughput is one instruction per cycle.
- The first instruction (address 0) is written 3 edges after reset deassertion.
- The first cycle after reset deassertion never produces a write, because fetch-valid is 0.
- Reset asserted mid-stream clears PC, the pipeline and the regfile immediately. In-flight instructions are discarded.
- Back-to-back dependent instructions (e.g. ADDI x1 followed by SLTIU x8,x1,…) give architecturally correct results.

## Test plan
- Reset then ADDI x1,x0,5; SLTIU x8,x1,6; SLTIU x9,x1,5 -> x1=5, x8=1, x9=0 after the program plus 3 cycles.
- ADDI x2,x0,-1; SLTI x3,x2,0; SLTIU x4,x2,1; SLTIU x5,x0,-1 -> x2=0xFFFFFFFF, x3=1, x4=0, x5=1.
- LUI x6,0x80000; SRAI x7,x6,4; SRLI x10,x6,4; XORI x11,x6,-1 -> x6=0x80000000, x7=0xF8000000, x10=0x08000000, x11=0x7FFFFFFF.
- ADDI x0,x0,7; ORI x12,x0,0x0F0; ANDI x13,x12,0x0FF; SLLI x14,x13,28 -> x0=0, x12=0xF0, x13=0xF0, x14=0.
- Unsupported word 0x00000063 (BEQ) between two ADDIs -> no register change, PC keeps incrementing by 4, and the data port stays at 0 throughout.
- Assert rstn_i mid-program -> PC=0 and all registers=0 immediately; after release the program re-executes from address 0 with identical results.

Source files
------------

// File: rtl/jedro_1_core.sv
// Minimal RV32I core: three-stage pipeline (fetch, decode-register, execute/writeback)
// executing OP-IMM ALU instructions and LUI; every other encoding retires as a NOP.

module jedro_1_regfile #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [4:0]            raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [4:0]            raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);
  logic [DATA_WIDTH-1:0] regfile [0:31];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regfile[waddr] <= wdata;
    end
  end

  // x0 is hardwired to zero on both read ports.
  assign rdata_a = (raddr_a == 5'd0) ? '0 : regfile[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regfile[raddr_b];
endmodule

module jedro_1_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [3:0]            data_we_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);
  localparam logic [6:0]            OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]            OPC_LUI    = 7'b0110111;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0] pc;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] dec_instr;
  logic                  dec_valid;

  // Fetch: the PC is the address presented to the synchronous ROM.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc          <= '0;
      fetch_valid <= 1'b0;
    end else begin
      pc          <= pc + ADDR_WIDTH'(4);
      fetch_valid <= 1'b1;
    end
  end

  // Decode register: the ROM word is only trusted once a real fetch has been issued.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dec_instr <= NOP_INSTR;
      dec_valid <= 1'b0;
    end else begin
      dec_instr <= fetch_valid ? instr_rdata_i : NOP_INSTR;
      dec_valid <= fetch_valid;
    end
  end

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_en;

  assign opcode = dec_instr[6:0];
  assign funct3 = dec_instr[14:12];
  assign rd     = dec_instr[11:7];
  assign rs1    = dec_instr[19:15];
  assign rs2    = dec_instr[24:20];
  assign shamt  = dec_instr[24:20];
  assign imm_i  = {{(DATA_WIDTH-12){dec_instr[31]}}, dec_instr[31:20]};
  assign imm_u  = {dec_instr[31:12], {(DATA_WIDTH-20){1'b0}}};

  jedro_1_regfile #(.DATA_WIDTH(DATA_WIDTH)) regfile_inst (
    .clk     (clk_i),
    .rstn    (rstn_i),
    .we      (wb_en),
    .waddr   (rd),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .rdata_a (rs1_data),
    .raddr_b (rs2),
    .rdata_b (rs2_data)
  );

  // Execute/writeback: operands are read here, so a result written at an edge
  // is already visible to the instruction executing in the following cycle.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    if (dec_valid) begin
      if (opcode == OPC_LUI) begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end else if (opcode == OPC_OP_IMM) begin
        wb_en = 1'b1;
        case (funct3)
          3'b000: wb_data = rs1_data + imm_i;
          3'b010: wb_data = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_data) < $signed(imm_i))};
          3'b011: wb_data = {{(DATA_WIDTH-1){1'b0}}, (rs1_data < imm_i)};
          3'b100: wb_data = rs1_data ^ imm_i;
          3'b110: wb_data = rs1_data | imm_i;
          3'b111: wb_data = rs1_data & imm_i;
          3'b001: wb_data = rs1_data << shamt;
          default: wb_data = dec_instr[30] ? DATA_WIDTH'($signed(rs1_data) >>> shamt)
                                           : (rs1_data >> shamt);
        endcase
      end
    end
  end

  assign instr_addr_o = pc;
  assign data_addr_o  = '0;
  assign data_wdata_o = '0;
  assign data_we_o    = 4'b0000;

  // Data read port and second register read port are not consumed by this core.
  logic unused_inputs;
  assign unused_inputs = ^{data_rdata_i, rs2_data};
endmodule

// File: tb/tb_jedro_1_core.sv
// Bench for jedro_1_core: table of programs with expected register results,
// checked through an expected queue as each instruction retires.

module tb_jedro_1_core;
  localparam int W = 37;  // {rd[4:0], value[31:0]}

  logic        clk;
  logic        rstn;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;
  logic [31:0] data_rdata;

  jedro_1_core #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .instr_addr_o  (instr_addr),
    .instr_rdata_i (instr_rdata),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .data_we_o     (data_we),
    .data_rdata_i  (data_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction ROM.
  logic [31:0] imem [0:63];
  always @(posedge clk) instr_rdata <= imem[instr_addr[7:2]];

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vec [0:17];
  int   prog_start [0:4];
  int   prog_len   [0:4];

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rd,
                              input logic [31:0] exp);
    vec_t v;
    v.instr = instr;
    v.rd    = rd;
    v.exp   = exp;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_regs_zero(input string tag);
    for (int r = 0; r < 32; r++)
      check($sformatf("%s x%0d", tag, r), dut.regfile_inst.regfile[r], 32'h0);
  endtask

  // ---------------- driver ----------------
  // Loads a program, resets, then runs it. Instruction n is addressed in cycle n
  // and must appear in the regfile after edge n+3. abort_at < 0 runs to completion.
  task automatic run_prog(input int p, input int abort_at);
    logic [W-1:0] e;
    int start;
    int len;
    start = prog_start[p];
    len   = prog_len[p];
    rstn  = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < len; i++) imem[i] = vec[start + i].instr;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rstn = 1'b1;
    for (int n = 0; n < len + 4; n++) begin
      if (n > 0) @(negedge clk);
      data_rdata = $urandom_range(32'hFFFF_FFFF, 0);
      check($sformatf("p%0d pc c%0d", p, n), instr_addr, 32'(4 * n));
      check($sformatf("p%0d data c%0d", p, n), data_addr | data_wdata | {28'h0, data_we}, 32'h0);
      if (n == abort_at) begin
        rstn = 1'b0;
        #1;
        check($sformatf("p%0d pc after abort", p), instr_addr, 32'h0);
        check_regs_zero($sformatf("p%0d abort", p));
        exp_q.delete();
        return;
      end
      if (n < len) exp_q.push_back({vec[start + n].rd, vec[start + n].exp});
      if (n >= 3 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("p%0d i%0d x%0d", p, n - 3, e[36:32]),
              dut.regfile_inst.regfile[e[36:32]], e[31:0]);
      end
    end
    check($sformatf("p%0d queue drained", p), 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    rstn       = 1'b0;
    data_rdata = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;

    // ADDI / SLTIU with dependency on the previous result.
    vec[0]  = mk(enc_i(3'b000, 5'd1,  5'd0, 12'd5),   5'd1,  32'd5);
    vec[1]  = mk(enc_i(3'b011, 5'd8,  5'd1, 12'd6),   5'd8,  32'd1);
    vec[2]  = mk(enc_i(3'b011, 5'd9,  5'd1, 12'd5),   5'd9,  32'd0);
    // Signed/unsigned compares against -1.
    vec[3]  = mk(enc_i(3'b000, 5'd2,  5'd0, 12'hFFF), 5'd2,  32'hFFFF_FFFF);
    vec[4]  = mk(enc_i(3'b010, 5'd3,  5'd2, 12'h000), 5'd3,  32'd1);
    vec[5]  = mk(enc_i(3'b011, 5'd4,  5'd2, 12'h001), 5'd4,  32'd0);
    vec[6]  = mk(enc_i(3'b011, 5'd5,  5'd0, 12'hFFF), 5'd5,  32'd1);
    // LUI and shifts.
    vec[7]  = mk(enc_lui(5'd6, 20'h80000),            5'd6,  32'h8000_0000);
    vec[8]  = mk(enc_i(3'b101, 5'd7,  5'd6, 12'h404), 5'd7,  32'hF800_0000);
    vec[9]  = mk(enc_i(3'b101, 5'd10, 5'd6, 12'h004), 5'd10, 32'h0800_0000);
    vec[10] = mk(enc_i(3'b100, 5'd11, 5'd6, 12'hFFF), 5'd11, 32'h7FFF_FFFF);
    // x0 write discard, logic ops, shift-out.
    vec[11] = mk(enc_i(3'b000, 5'd0,  5'd0, 12'd7),   5'd0,  32'h0);
    vec[12] = mk(enc_i(3'b110, 5'd12, 5'd0, 12'h0F0), 5'd12, 32'h0000_00F0);
    vec[13] = mk(enc_i(3'b111, 5'd13, 5'd12, 12'h0FF), 5'd13, 32'h0000_00F0);
    vec[14] = mk(enc_i(3'b001, 5'd14, 5'd13, 12'h01C), 5'd14, 32'h0);
    // Unsupported BEQ between ADDIs: x15 must be unchanged after it retires.
    vec[15] = mk(enc_i(3'b000, 5'd15, 5'd0, 12'd3),   5'd15, 32'd3);
    vec[16] = mk(32'h0000_0063,                       5'd15, 32'd3);
    vec[17] = mk(enc_i(3'b000, 5'd16, 5'd15, 12'd1),  5'd16, 32'd4);

    prog_start[0] = 0;  prog_len[0] = 3;
    prog_start[1] = 3;  prog_len[1] = 4;
    prog_start[2] = 7;  prog_len[2] = 4;
    prog_start[3] = 11; prog_len[3] = 4;
    prog_start[4] = 15; prog_len[4] = 3;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset pc", instr_addr, 32'h0);
    check("reset data", data_addr | data_wdata | {28'h0, data_we}, 32'h0);
    check_regs_zero("reset");

    for (int p = 0; p < 5; p++) run_prog(p, -1);

    // Mid-program reset after two instructions have retired, then a clean rerun.
    run_prog(0, 4);
    run_prog(0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
